// File: rtl/ahb_bus_arbiter_pkg.sv
// ahb_bus_arbiter_pkg: shared AHB transfer/burst encodings and arbiter state.
// ahb_burst_beats gives the fixed beat count of a burst, 1 for SINGLE/INCR.
package ahb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } ahb_trans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } ahb_burst_e;

    typedef enum logic [1:0] {
        PARK,
        OWN,
        BURST,
        LOCKED
    } ahb_arb_state_e;

    function automatic int ahb_burst_beats(ahb_burst_e b);
        int beats;
        case (b)
            WRAP4, INCR4:   beats = 4;
            WRAP8, INCR8:   beats = 8;
            WRAP16, INCR16: beats = 16;
            default:        beats = 1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_priority_picker.sv
// ahb_rr_priority_picker: combinational round-robin pick of the first request
// strictly after ptr_i, wrapping around; returns one-hot and index.
module ahb_rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0]   hi;
    logic [2*N-1:0] dreq;
    logic [2*N-1:0] dpick;

    always_comb begin
        hi = '0;
        for (int i = 0; i < N; i++) begin
            hi[i] = (i > int'(ptr_i));
        end
    end

    // Lower half holds requests above the pointer, upper half the wrapped set.
    assign dreq  = {req_i, req_i & hi};
    assign dpick = dreq & ~(dreq - (2*N)'(1));
    assign gnt_o = dpick[N-1:0] | dpick[2*N-1:N];

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter that never breaks fixed bursts or
// locked sequences; hmaster/hmastlock follow the grant on hready.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NO_OF_MASTERS  = 1,
    parameter int HMASTER_WIDTH  = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic [NO_OF_MASTERS-1:0] hbusreq,
    input  logic [NO_OF_MASTERS-1:0] hlock,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hburst,
    input  logic                     hready,
    output logic [NO_OF_MASTERS-1:0] hgrant,
    output logic [HMASTER_WIDTH-1:0] hmaster,
    output logic                     hmastlock
);

    localparam logic [NO_OF_MASTERS-1:0] DefGnt =
        NO_OF_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [HMASTER_WIDTH-1:0] DefIdx =
        HMASTER_WIDTH'(DEFAULT_MASTER);

    ahb_arb_state_e             state_q;
    logic [3:0]                 cnt_q;
    logic [3:0]                 blast_q;
    logic [NO_OF_MASTERS-1:0]   hgrant_q;
    logic [HMASTER_WIDTH-1:0]   gidx_q;
    logic [HMASTER_WIDTH-1:0]   ptr_q;
    logic [HMASTER_WIDTH-1:0]   hmaster_q;
    logic                       hmastlock_q;

    ahb_trans_e                 trans;
    ahb_burst_e                 burst;
    logic                       own_lock;
    logic                       start;
    logic                       last;
    logic                       rap;
    logic [NO_OF_MASTERS-1:0]   win;
    logic [HMASTER_WIDTH-1:0]   win_idx;

    assign trans    = ahb_trans_e'(htrans);
    assign burst    = ahb_burst_e'(hburst);
    assign own_lock = |(hlock & hgrant_q);
    assign start    = hready && trans == NONSEQ
                      && ahb_burst_beats(burst) > 1;
    assign last     = trans == SEQ && (cnt_q + 4'd1) == blast_q;

    ahb_rr_priority_picker #(
        .N  (NO_OF_MASTERS),
        .IW (HMASTER_WIDTH)
    ) u_picker (
        .req_i (hbusreq),
        .ptr_i (ptr_q),
        .gnt_o (win),
        .idx_o (win_idx)
    );

    // A fixed-burst NONSEQ never re-arbitrates; it opens the burst instead.
    always_comb begin
        rap = 1'b0;
        unique case (state_q)
            PARK:   rap = hready && !start;
            OWN:    rap = hready && !start
                          && (trans == IDLE || trans == NONSEQ
                              || (trans == SEQ && burst == INCR));
            BURST:  rap = hready
                          && (trans == IDLE || trans == NONSEQ || last);
            LOCKED: rap = hready && !own_lock;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= PARK;
            cnt_q       <= '0;
            blast_q     <= '0;
            hgrant_q    <= DefGnt;
            gidx_q      <= DefIdx;
            ptr_q       <= DefIdx;
            hmaster_q   <= DefIdx;
            hmastlock_q <= 1'b0;
        end else begin
            if (hready) begin
                hmaster_q   <= gidx_q;
                hmastlock_q <= own_lock;
            end
            if (rap) begin
                cnt_q <= '0;
                if (own_lock) begin
                    state_q <= LOCKED;
                end else if (|hbusreq) begin
                    hgrant_q <= win;
                    gidx_q   <= win_idx;
                    ptr_q    <= win_idx;
                    state_q  <= OWN;
                end else begin
                    hgrant_q <= DefGnt;
                    gidx_q   <= DefIdx;
                    state_q  <= PARK;
                end
            end else if (start && state_q != LOCKED) begin
                cnt_q   <= '0;
                blast_q <= 4'(ahb_burst_beats(burst) - 1);
                state_q <= BURST;
            end else if (state_q == BURST && hready
                         && trans == SEQ && cnt_q != 4'hF) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed vector table plus hand sequences for bursts,
// early burst termination and reset mid-burst on a 4-manager arbiter.
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic         hclk = 1'b0;
    logic         hresetn = 1'b0;
    logic [N-1:0] hbusreq = '0;
    logic [N-1:0] hlock = '0;
    logic [1:0]   htrans = IDLE;
    logic [2:0]   hburst = SINGLE;
    logic         hready = 1'b1;
    logic [N-1:0] hgrant;
    logic [W-1:0] hmaster;
    logic         hmastlock;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] g;
        logic [3:0] m;
        logic       ml;
    } vec_t;

    vec_t vt[$];

    ahb_bus_arbiter #(
        .NO_OF_MASTERS  (N),
        .HMASTER_WIDTH  (W),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic [3:0] m, input logic ml);
        cmp({nm, ".hgrant"}, 32'(hgrant), 32'(g));
        cmp({nm, ".hmaster"}, 32'(hmaster), 32'(m));
        cmp({nm, ".hmastlock"}, 32'(hmastlock), 32'(ml));
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] lock,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy);
        hbusreq = req;
        hlock   = lock;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        hbusreq = '0;
        hlock   = '0;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        @(posedge hclk);
        #1;
        chk("reset", 4'b0001, 4'h0, 1'b0);
        hresetn = 1'b1;
    endtask

    task automatic add(input logic rst, input logic [3:0] req,
                       input logic [3:0] lock, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy,
                       input logic [3:0] g, input logic [3:0] m,
                       input logic ml);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.tr = tr;
        v.bu = bu; v.rdy = rdy; v.g = g; v.m = m; v.ml = ml;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Round robin between M1 and M2 on SINGLE traffic, then park.
        add(1, 4'b0110, 4'b0000, IDLE,   SINGLE, 1, 4'b0010, 4'h0, 0);
        add(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 4'b0100, 4'h1, 0);
        add(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 4'b0010, 4'h2, 0);
        add(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 4'b0100, 4'h1, 0);
        add(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 0, 4'b0100, 4'h1, 0);
        add(0, 4'b0110, 4'b0000, NONSEQ, SINGLE, 1, 4'b0010, 4'h2, 0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 4'h1, 0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 4'h0, 0);
        // M3 locked over two SINGLEs with M0 waiting.
        add(1, 4'b1001, 4'b1000, IDLE,   SINGLE, 1, 4'b1000, 4'h0, 0);
        add(0, 4'b1001, 4'b1000, IDLE,   SINGLE, 1, 4'b1000, 4'h3, 1);
        add(0, 4'b1001, 4'b1000, NONSEQ, SINGLE, 1, 4'b1000, 4'h3, 1);
        add(0, 4'b1001, 4'b1000, NONSEQ, SINGLE, 1, 4'b1000, 4'h3, 1);
        add(0, 4'b0001, 4'b0000, IDLE,   SINGLE, 0, 4'b1000, 4'h3, 1);
        add(0, 4'b0001, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 4'h3, 0);
        add(0, 4'b0000, 4'b0000, IDLE,   SINGLE, 1, 4'b0001, 4'h0, 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
            chk($sformatf("park%0d", i), 4'b0001, 4'h0, 1'b0);
        end

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            step(vt[i].req, vt[i].lock, vt[i].tr, vt[i].bu, vt[i].rdy);
            chk($sformatf("vec%0d", i), vt[i].g, vt[i].m, vt[i].ml);
        end

        // M1 INCR8 with wait states, M2 waiting until the last beat.
        do_reset();
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("b8_grant", 4'b0010, 4'h0, 1'b0);
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("b8_own", 4'b0010, 4'h1, 1'b0);
        step(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1);
        chk("b8_b1", 4'b0010, 4'h1, 1'b0);
        for (int b = 2; b <= 8; b++) begin
            if (b == 3 || b == 5) begin
                step(4'b0110, 4'b0000, SEQ, INCR8, 1'b0);
                chk($sformatf("b8_wait%0d", b), 4'b0010, 4'h1, 1'b0);
            end
            step(4'b0110, 4'b0000, SEQ, INCR8, 1'b1);
            chk($sformatf("b8_b%0d", b),
                (b == 8) ? 4'b0100 : 4'b0010, 4'h1, 1'b0);
        end
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("b8_after", 4'b0100, 4'h2, 1'b0);

        // M2 WRAP4 cut short by IDLE, then a full M3 INCR4.
        do_reset();
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("w4_grant", 4'b0100, 4'h0, 1'b0);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("w4_own", 4'b0100, 4'h2, 1'b0);
        step(4'b1100, 4'b0000, NONSEQ, WRAP4, 1'b1);
        chk("w4_b1", 4'b0100, 4'h2, 1'b0);
        step(4'b1100, 4'b0000, SEQ, WRAP4, 1'b1);
        chk("w4_b2", 4'b0100, 4'h2, 1'b0);
        step(4'b1100, 4'b0000, IDLE, WRAP4, 1'b1);
        chk("w4_abort", 4'b1000, 4'h2, 1'b0);
        step(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("i4_own", 4'b1000, 4'h3, 1'b0);
        step(4'b1100, 4'b0000, NONSEQ, INCR4, 1'b1);
        chk("i4_b1", 4'b1000, 4'h3, 1'b0);
        for (int b = 2; b <= 4; b++) begin
            step(4'b1100, 4'b0000, SEQ, INCR4, 1'b1);
            chk($sformatf("i4_b%0d", b),
                (b == 4) ? 4'b0100 : 4'b1000, 4'h3, 1'b0);
        end

        // Reset asserted in the middle of an M1 INCR16.
        do_reset();
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        step(4'b0010, 4'b0000, NONSEQ, INCR16, 1'b1);
        for (int b = 2; b <= 7; b++) begin
            step(4'b0010, 4'b0000, SEQ, INCR16, 1'b1);
        end
        chk("i16_b7", 4'b0010, 4'h1, 1'b0);
        #2;
        hresetn = 1'b0;
        #1;
        chk("i16_async_rst", 4'b0001, 4'h0, 1'b0);
        @(posedge hclk);
        #1;
        chk("i16_rst_hold", 4'b0001, 4'h0, 1'b0);
        hresetn = 1'b1;
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        chk("i16_park", 4'b0001, 4'h0, 1'b0);
        step(4'b0100, 4'b0000, SEQ, INCR16, 1'b1);
        chk("i16_restart", 4'b0100, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
